// File: rtl/fifo_wptr_full_if.sv
// Write-side bus of the async FIFO pointer/flag block.
// FIFO_WR_OVF_CNT_EN adds the overflow counter clear/readout signals.
interface fifo_wptr_full_if #(
  parameter int unsigned PTR_SIZE = 8
);
  localparam int unsigned PW = PTR_SIZE + 1;

  logic          w_en;
  logic [PW-1:0] g_rptr;
  logic [PW-1:0] b_wptr;
  logic [PW-1:0] g_wptr;
  logic          full;
  logic          almost_full;
  logic [PW-1:0] wr_level;
`ifdef FIFO_WR_OVF_CNT_EN
  logic          ovf_clr;
  logic [15:0]   ovf_cnt;
`endif

`ifdef FIFO_WR_OVF_CNT_EN
  modport master (output w_en, g_rptr, ovf_clr,
                  input  b_wptr, g_wptr, full, almost_full, wr_level, ovf_cnt);
  modport slave  (input  w_en, g_rptr, ovf_clr,
                  output b_wptr, g_wptr, full, almost_full, wr_level, ovf_cnt);
`else
  modport master (output w_en, g_rptr,
                  input  b_wptr, g_wptr, full, almost_full, wr_level);
  modport slave  (input  w_en, g_rptr,
                  output b_wptr, g_wptr, full, almost_full, wr_level);
`endif
endinterface

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full/almost_full and fill-level generator for the async FIFO.
// Optional overflow counter enabled by defining FIFO_WR_OVF_CNT_EN.
module fifo_wptr_full #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned PTR_SIZE    = 8,
  parameter int unsigned AF_MARGIN   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              w_clk,
  input logic              w_rst,
  fifo_wptr_full_if.slave  bus
);
  localparam int unsigned PW = PTR_SIZE + 1;

  logic [PW-1:0] b_wptr_q, g_wptr_q, wr_level_q;
  logic          full_q, almost_full_q;
  logic [PW-1:0] sync_q [SYNC_STAGES];

  logic          wr_accept;
  logic [PW-1:0] g_rptr_s, b_rptr_s;
  logic [PW-1:0] b_wptr_next, g_wptr_next, wr_level_next, free_next;
  logic          full_next, almost_full_next;

  // Plain flop chain for the asynchronous Gray read pointer
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= bus.g_rptr;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign g_rptr_s = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    b_rptr_s = '0;
    for (int unsigned i = 0; i < PW; i++) b_rptr_s[i] = ^(g_rptr_s >> i);
  end

  always_comb begin
    wr_accept        = bus.w_en & ~full_q;
    b_wptr_next      = b_wptr_q + PW'(wr_accept);
    g_wptr_next      = b_wptr_next ^ (b_wptr_next >> 1);
    full_next        = (g_wptr_next == {~g_rptr_s[PW-1:PW-2], g_rptr_s[PW-3:0]});
    wr_level_next    = b_wptr_next - b_rptr_s;
    free_next        = PW'(DEPTH) - wr_level_next;
    almost_full_next = (free_next <= PW'(AF_MARGIN));
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      b_wptr_q      <= '0;
      g_wptr_q      <= '0;
      wr_level_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      b_wptr_q      <= b_wptr_next;
      g_wptr_q      <= g_wptr_next;
      wr_level_q    <= wr_level_next;
      full_q        <= full_next;
      almost_full_q <= almost_full_next;
    end
  end

  assign bus.b_wptr      = b_wptr_q;
  assign bus.g_wptr      = g_wptr_q;
  assign bus.wr_level    = wr_level_q;
  assign bus.full        = full_q;
  assign bus.almost_full = almost_full_q;

`ifdef FIFO_WR_OVF_CNT_EN
  logic [15:0] ovf_q;

  // Counts rejected write attempts; clear wins over increment, saturates at max
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      ovf_q <= '0;
    end else if (bus.ovf_clr) begin
      ovf_q <= '0;
    end else if (bus.w_en && full_q && (ovf_q != 16'hFFFF)) begin
      ovf_q <= ovf_q + 16'd1;
    end
  end

  assign bus.ovf_cnt = ovf_q;
`endif
endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed self-checking bench for fifo_wptr_full (DEPTH 256, AF_MARGIN 4, 2 sync stages).
module tb_fifo_wptr_full;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fifo_wptr_full_if #(.PTR_SIZE(8)) bus ();

  fifo_wptr_full #(
    .DEPTH(256), .PTR_SIZE(8), .AF_MARGIN(4), .SYNC_STAGES(2)
  ) dut (
    .w_clk (clk),
    .w_rst (rst),
    .bus   (bus.slave)
  );

  function automatic logic [8:0] gray(input logic [8:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.w_en = 1'b0;
    bus.g_rptr = '0;
`ifdef FIFO_WR_OVF_CNT_EN
    bus.ovf_clr = 1'b0;
`endif
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.w_en = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    #2;
    checks++;
    if (bus.b_wptr !== 9'd0 || bus.g_wptr !== 9'd0 || bus.full !== 1'b0 ||
        bus.almost_full !== 1'b0 || bus.wr_level !== 9'd0) begin
      errors++;
      $display("FAIL reset_async b=%h g=%h f=%b af=%b lvl=%0d want all zero",
               bus.b_wptr, bus.g_wptr, bus.full, bus.almost_full, bus.wr_level);
    end
    tick();
    checks++;
    if (bus.b_wptr !== 9'd0) begin
      errors++;
      $display("FAIL reset_hold b_wptr=%h want 000", bus.b_wptr);
    end
    rst = 1'b0;
    bus.w_en = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.b_wptr !== 9'd0 || bus.g_wptr !== 9'd0 || bus.full !== 1'b0 ||
        bus.almost_full !== 1'b0 || bus.wr_level !== 9'd0) begin
      errors++;
      $display("FAIL reset_idle b=%h g=%h f=%b af=%b lvl=%0d want all zero",
               bus.b_wptr, bus.g_wptr, bus.full, bus.almost_full, bus.wr_level);
    end
  endtask

  task automatic test_almost_full();
    do_reset();
    bus.w_en = 1'b1;
    for (int i = 1; i <= 252; i++) begin
      tick();
      if (i == 251) begin
        checks++;
        if (bus.almost_full !== 1'b0 || bus.wr_level !== 9'd251) begin
          errors++;
          $display("FAIL af_251 af=%b lvl=%0d want af=0 lvl=251", bus.almost_full, bus.wr_level);
        end
      end
    end
    bus.w_en = 1'b0;
    checks++;
    if (bus.almost_full !== 1'b1 || bus.full !== 1'b0 || bus.wr_level !== 9'd252 ||
        bus.b_wptr !== 9'd252) begin
      errors++;
      $display("FAIL af_252 af=%b f=%b lvl=%0d b=%h want af=1 f=0 lvl=252 b=0fc",
               bus.almost_full, bus.full, bus.wr_level, bus.b_wptr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.w_en = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 255) begin
        checks++;
        if (bus.full !== 1'b0 || bus.b_wptr !== 9'h0ff) begin
          errors++;
          $display("FAIL b2b_255 f=%b b=%h want f=0 b=0ff", bus.full, bus.b_wptr);
        end
      end
    end
    checks++;
    if (bus.full !== 1'b1 || bus.b_wptr !== 9'h100 || bus.g_wptr !== 9'h180 ||
        bus.wr_level !== 9'd256) begin
      errors++;
      $display("FAIL b2b_256 f=%b b=%h g=%h lvl=%0d want f=1 b=100 g=180 lvl=256",
               bus.full, bus.b_wptr, bus.g_wptr, bus.wr_level);
    end
    tick();
    bus.w_en = 1'b0;
    checks++;
    if (bus.b_wptr !== 9'h100 || bus.full !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reject b=%h f=%b want b=100 f=1", bus.b_wptr, bus.full);
    end
  endtask

  task automatic test_read_release();
    bus.g_rptr = gray(9'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (bus.full !== (i < 3)) begin
        errors++;
        $display("FAIL rel_cycle%0d full=%b want %b", i, bus.full, (i < 3));
      end
    end
    checks++;
    if (bus.wr_level !== 9'd255 || bus.almost_full !== 1'b1) begin
      errors++;
      $display("FAIL rel_level lvl=%0d af=%b want lvl=255 af=1", bus.wr_level, bus.almost_full);
    end
    bus.w_en = 1'b1;
    tick();
    bus.w_en = 1'b0;
    checks++;
    if (bus.b_wptr !== 9'h101 || bus.full !== 1'b1 || bus.wr_level !== 9'd256) begin
      errors++;
      $display("FAIL rel_refill b=%h f=%b lvl=%0d want b=101 f=1 lvl=256",
               bus.b_wptr, bus.full, bus.wr_level);
    end
  endtask

  task automatic test_simultaneous();
    bus.g_rptr = gray(9'd2);
    bus.w_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (bus.b_wptr !== ((i < 4) ? 9'h101 : 9'h102) || bus.full !== (i != 3)) begin
        errors++;
        $display("FAIL simul_cycle%0d b=%h f=%b want b=%h f=%b", i, bus.b_wptr, bus.full,
                 ((i < 4) ? 9'h101 : 9'h102), (i != 3));
      end
    end
    bus.w_en = 1'b0;
  endtask

  task automatic test_wrap();
    logic [8:0] wb, rb, h0, h1, h2, exp_lvl;
    int bad = 0;
    do_reset();
    wb = '0; rb = '0; h0 = '0; h1 = '0; h2 = '0;
    for (int n = 0; n < 600; n++) begin
      if (9'(wb - rb) > 9'd10) rb = rb + 9'd1;
      bus.g_rptr = gray(rb);
      h2 = h1; h1 = h0; h0 = rb;
      bus.w_en = 1'b1;
      tick();
      wb = wb + 9'd1;
      exp_lvl = wb - h2;
      checks++;
      if (bus.b_wptr !== wb || bus.full !== 1'b0 || bus.almost_full !== 1'b0 ||
          bus.wr_level !== exp_lvl) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL wrap_n%0d b=%h f=%b af=%b lvl=%0d want b=%h f=0 af=0 lvl=%0d",
                   n, bus.b_wptr, bus.full, bus.almost_full, bus.wr_level, wb, exp_lvl);
      end
    end
    bus.w_en = 1'b0;
  endtask

`ifdef FIFO_WR_OVF_CNT_EN
  task automatic test_ovf();
    do_reset();
    bus.w_en = 1'b1;
    repeat (256) tick();
    repeat (5) tick();
    checks++;
    if (bus.ovf_cnt !== 16'd5 || bus.b_wptr !== 9'h100) begin
      errors++;
      $display("FAIL ovf_count cnt=%0d b=%h want cnt=5 b=100", bus.ovf_cnt, bus.b_wptr);
    end
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    checks++;
    if (bus.ovf_cnt !== 16'd0) begin
      errors++;
      $display("FAIL ovf_clr cnt=%0d want 0", bus.ovf_cnt);
    end
    repeat (2) tick();
    checks++;
    if (bus.ovf_cnt !== 16'd2) begin
      errors++;
      $display("FAIL ovf_recount cnt=%0d want 2", bus.ovf_cnt);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (bus.ovf_cnt !== 16'd0) begin
      errors++;
      $display("FAIL ovf_rst cnt=%0d want 0", bus.ovf_cnt);
    end
    bus.w_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask
`endif

  initial begin
    bus.w_en = 1'b0;
    bus.g_rptr = '0;
`ifdef FIFO_WR_OVF_CNT_EN
    bus.ovf_clr = 1'b0;
`endif
    test_reset();
    test_almost_full();
    test_back_to_back();
    test_read_release();
    test_simultaneous();
    test_wrap();
`ifdef FIFO_WR_OVF_CNT_EN
    test_ovf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
